// File: rtl/yuv422_word_packer.sv
// Packs the CTE 4:2:2 byte stream (U,Y0,V,Y1) into 32-bit words and queues them
// in a small FWFT FIFO drained by a valid/ready handshake.
module yuv422_word_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int AF_LEVEL   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        yuv_valid,
  input  logic [7:0]  yuv_in,
  input  logic        sof,
  input  logic        uv_offset,
  output logic        word_valid,
  output logic [31:0] word_out,
  input  logic        word_ready,
  output logic        almost_full,
  output logic        overflow,
  output logic [15:0] pair_cnt,
  output logic [1:0]  phase
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [7:0] chroma_fix(input logic [7:0] b, input logic en);
    return en ? (b ^ 8'h80) : b;
  endfunction

  logic [1:0]       phase_q, phase_d;
  logic [23:0]      asm_q, asm_d;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wv_q, af_q, ovf_q, ovf_d;
  logic [15:0]      pair_cnt_q, pair_cnt_d;
  logic             push_req_s, push_ok_s, pop_s;
  logic [31:0]      push_word_s;

  // Byte assembly: sof realigns to slot 0 and discards any partial word.
  always_comb begin
    phase_d     = phase_q;
    asm_d       = asm_q;
    push_req_s  = 1'b0;
    push_word_s = {asm_q, yuv_in};
    if (yuv_valid) begin
      if (sof) begin
        phase_d = 2'd1;
        asm_d   = {chroma_fix(yuv_in, uv_offset), 16'h0000};
      end else begin
        phase_d = phase_q + 2'd1;
        case (phase_q)
          2'd0:    asm_d[23:16] = chroma_fix(yuv_in, uv_offset);
          2'd1:    asm_d[15:8]  = yuv_in;
          2'd2:    asm_d[7:0]   = chroma_fix(yuv_in, uv_offset);
          2'd3:    push_req_s   = 1'b1;
          default: asm_d        = asm_q;
        endcase
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // A full FIFO still accepts a word when the head leaves on the same edge.
  always_comb begin
    pop_s      = (count_q != {CNT_W{1'b0}}) & word_ready;
    push_ok_s  = push_req_s & ((count_q < CNT_W'(FIFO_DEPTH)) | pop_s);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pair_cnt_d = pair_cnt_q;
    ovf_d      = ovf_q | (push_req_s & ~push_ok_s);
    if (push_ok_s) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      pair_cnt_d = pair_cnt_q + 16'd1;
    end else begin
      wr_ptr_d   = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q    <= 2'd0;
      asm_q      <= 24'h000000;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      wv_q       <= 1'b0;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      pair_cnt_q <= 16'h0000;
    end else begin
      phase_q    <= phase_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wv_q       <= (count_d != {CNT_W{1'b0}});
      af_q       <= (count_d >= CNT_W'(AF_LEVEL));
      ovf_q      <= ovf_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  // Storage needs no reset; only entries behind the valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (reset && push_ok_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

  assign word_valid  = wv_q;
  assign word_out    = wv_q ? mem_q[rd_ptr_q] : 32'h00000000;
  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign pair_cnt    = pair_cnt_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_yuv422_word_packer.sv
// Directed self-checking bench for yuv422_word_packer; inputs change 1 ns after
// the rising edge and outputs are sampled there as well.
module tb_yuv422_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        yuv_valid = 1'b0;
  logic [7:0]  yuv_in = 8'h00;
  logic        sof = 1'b0;
  logic        uv_offset = 1'b0;
  logic        word_valid;
  logic [31:0] word_out;
  logic        word_ready = 1'b0;
  logic        almost_full;
  logic        overflow;
  logic [15:0] pair_cnt;
  logic [1:0]  phase;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] w [5];

  yuv422_word_packer #(.FIFO_DEPTH(4), .AF_LEVEL(3)) dut (
    .clk(clk), .reset(reset), .yuv_valid(yuv_valid), .yuv_in(yuv_in), .sof(sof),
    .uv_offset(uv_offset), .word_valid(word_valid), .word_out(word_out),
    .word_ready(word_ready), .almost_full(almost_full), .overflow(overflow),
    .pair_cnt(pair_cnt), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    yuv_valid = 1'b1;
    yuv_in    = b;
    sof       = s;
    tick();
    yuv_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] x);
    send_byte(x[31:24], 1'b0);
    send_byte(x[23:16], 1'b0);
    send_byte(x[15:8], 1'b0);
    send_byte(x[7:0], 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({word_valid, almost_full, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {word_valid, almost_full, overflow}); end
    n_checks++; if (word_out !== 32'h0) begin n_fail++; $display("FAIL reset_word got %h want 00000000", word_out); end
    n_checks++; if ({pair_cnt, phase} !== 18'h0) begin n_fail++; $display("FAIL reset_cnt_phase got %h/%0d want 0/0", pair_cnt, phase); end
  endtask

  task automatic test_basic_pack();
    do_reset();
    uv_offset = 1'b0; word_ready = 1'b1;
    send_word(32'h10203040);
    n_checks++; if (word_valid !== 1'b1 || word_out !== 32'h10203040) begin n_fail++; $display("FAIL basic_word got %b/%h want 1/10203040", word_valid, word_out); end
    n_checks++; if (pair_cnt !== 16'd1 || phase !== 2'd0) begin n_fail++; $display("FAIL basic_cnt got %0d/%0d want 1/0", pair_cnt, phase); end
    tick();
    n_checks++; if (word_valid !== 1'b0 || word_out !== 32'h0) begin n_fail++; $display("FAIL basic_one_cycle got %b/%h want 0/00000000", word_valid, word_out); end
  endtask

  task automatic test_offset_gaps();
    logic [7:0] b [4];
    b[0] = 8'hF0; b[1] = 8'h50; b[2] = 8'h0A; b[3] = 8'h60;
    do_reset();
    uv_offset = 1'b1; word_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte(b[i], 1'b0);
      if (i < 3) begin
        tick(); tick();
        n_checks++; if (phase !== 2'(i + 1)) begin n_fail++; $display("FAIL gap_phase_hold got %0d want %0d", phase, i + 1); end
      end
    end
    n_checks++; if (word_valid !== 1'b1 || word_out !== 32'h70508A60) begin n_fail++; $display("FAIL offset_word got %b/%h want 1/70508a60", word_valid, word_out); end
    uv_offset = 1'b0;
  endtask

  task automatic test_resync();
    do_reset();
    word_ready = 1'b0;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'hAA, 1'b1);
    n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL sof_phase got %0d want 1", phase); end
    send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
    n_checks++; if (word_out !== 32'hAABBCCDD || pair_cnt !== 16'd1 || overflow !== 1'b0) begin n_fail++; $display("FAIL resync_word got %h/%0d/%b want aabbccdd/1/0", word_out, pair_cnt, overflow); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL resync_single got %b want 0", word_valid); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_word(w[i]);
      if (i == 1) begin
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_after_w2 got %b want 0", almost_full); end
      end
      if (i == 2) begin
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL af_after_w3 got %b want 1", almost_full); end
      end
      if (i == 3) begin
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_after_w4 got %b want 0", overflow); end
      end
    end
    n_checks++; if (overflow !== 1'b1 || pair_cnt !== 16'd4 || phase !== 2'd0) begin n_fail++; $display("FAIL ovf_after_w5 got %b/%0d/%0d want 1/4/0", overflow, pair_cnt, phase); end
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (word_valid !== 1'b1 || word_out !== w[i]) begin n_fail++; $display("FAIL drain_%0d got %b/%h want 1/%h", i, word_valid, word_out, w[i]); end
      tick();
    end
    n_checks++; if (word_valid !== 1'b0 || overflow !== 1'b1 || almost_full !== 1'b0) begin n_fail++; $display("FAIL drain_end got %b/%b/%b want 0/1/0", word_valid, overflow, almost_full); end
    word_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(w[i]);
    send_byte(w[4][31:24], 1'b0); send_byte(w[4][23:16], 1'b0); send_byte(w[4][15:8], 1'b0);
    word_ready = 1'b1;
    send_byte(w[4][7:0], 1'b0);
    word_ready = 1'b0;
    n_checks++; if (overflow !== 1'b0 || pair_cnt !== 16'd5 || almost_full !== 1'b1) begin n_fail++; $display("FAIL full_pop_flags got %b/%0d/%b want 0/5/1", overflow, pair_cnt, almost_full); end
    tick();
    word_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (word_valid !== 1'b1 || word_out !== w[i]) begin n_fail++; $display("FAIL full_pop_drain_%0d got %b/%h want 1/%h", i, word_valid, word_out, w[i]); end
      tick();
    end
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_empty got %b want 0", word_valid); end
    word_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    word_ready = 1'b0;
    send_word(w[0]); send_word(w[1]);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    do_reset();
    n_checks++; if ({word_valid, almost_full, overflow, phase} !== 5'b0 || word_out !== 32'h0 || pair_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset got %b%b%b/%0d/%h/%0d want all 0", word_valid, almost_full, overflow, phase, word_out, pair_cnt); end
    send_word(32'h03040506);
    n_checks++; if (word_valid !== 1'b1 || word_out !== 32'h03040506 || pair_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_reset_word got %b/%h/%0d want 1/03040506/1", word_valid, word_out, pair_cnt); end
  endtask

  initial begin
    w[0] = 32'hA1B2C3D4; w[1] = 32'h05162738; w[2] = 32'h9ABCDEF0;
    w[3] = 32'h13579BDF; w[4] = 32'h2468ACE0;
    tick();
    test_reset();
    test_basic_pack();
    test_offset_gaps();
    test_resync();
    test_fill_overflow();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
